// File: rtl/spi_byte_engine_if.sv
// Byte handshake bundle between the SD sequencer (master) and the SPI byte engine (slave).
interface spi_byte_engine_if;
   logic [7:0] SendData;
   logic       SendReq;
   logic       SendAck;
   logic [7:0] RecvData;
   logic       RecvAdv;
   logic       RecvAck;

   modport master (output SendData, SendReq, RecvAck, input SendAck, RecvData, RecvAdv);
   modport slave  (input SendData, SendReq, RecvAck, output SendAck, RecvData, RecvAdv);
endinterface

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte engine: continuous MSB-first frames, filler 0xFF when nothing is offered.
// Define SPI_BYTE_ENGINE_OVERRUN_EN to add the sticky Overrun output.
//
// state       | meaning
// ST_BOUNDARY | sample Enable/Speed, load transmit byte, first divider cycle
// ST_SHIFT    | clocking the remaining half-periods of the frame
module spi_byte_engine #(
   parameter int unsigned SLOW_DIV = 104,
   parameter int unsigned FAST_DIV = 2
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Enable,
   input  logic Speed,
   spi_byte_engine_if.slave host,
   output logic SCLK,
   output logic MOSI,
   input  logic MISO,
   output logic SCE
`ifdef SPI_BYTE_ENGINE_OVERRUN_EN
   ,
   output logic Overrun
`endif
);

   localparam logic [9:0] SLOW_W = 10'(SLOW_DIV);
   localparam logic [9:0] FAST_W = 10'(FAST_DIV);

   typedef enum logic {ST_BOUNDARY, ST_SHIFT} state_t;

   state_t     state_q, state_d;
   logic [9:0] div_q, div_d, cnt_q, cnt_d, cnt_eff, div_sel;
   logic [2:0] bit_q, bit_d;
   logic [7:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
   logic       sclk_q, sclk_d, mosi_q, mosi_d, sce_q, sce_d, en_q, en_d;
   logic       ack_q, ack_d, adv_q, adv_d;
   logic       toggle, frame_end, accept;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      sce_d   = sce_q;
      en_d    = en_q;
      ack_d   = ack_q;
      adv_d   = adv_q;
      accept  = 1'b0;
      div_sel = Speed ? FAST_W : SLOW_W;
      cnt_eff = cnt_q;

      if (!host.SendReq) ack_d = 1'b0;

      // The boundary cycle is also the first count of the first low half-period.
      if (state_q == ST_BOUNDARY) begin
         div_d   = div_sel;
         en_d    = Enable;
         sce_d   = ~Enable;
         accept  = Enable & host.SendReq & ~ack_q;
         tx_d    = accept ? host.SendData : 8'hFF;
         mosi_d  = tx_d[7];
         cnt_eff = div_sel - 10'd1;
         state_d = ST_SHIFT;
         if (accept) ack_d = 1'b1;
      end

      toggle    = (cnt_eff == 10'd0);
      cnt_d     = toggle ? (div_d - 10'd1) : (cnt_eff - 10'd1);
      frame_end = toggle & sclk_q & (bit_q == 3'd7);

      if (toggle) begin
         sclk_d = ~sclk_q;
         if (!sclk_q) begin
            rx_d = {rx_q[6:0], MISO};
         end else begin
            bit_d  = bit_q + 3'd1;
            tx_d   = {tx_q[6:0], 1'b1};
            mosi_d = tx_d[7];
         end
      end

      if (frame_end) begin
         state_d = ST_BOUNDARY;
         if (en_q) begin
            rdata_d = rx_q;
            adv_d   = 1'b1;
         end
      end
      if (host.RecvAck) adv_d = 1'b0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_BOUNDARY;
         div_q   <= SLOW_W;
         cnt_q   <= 10'd0;
         bit_q   <= 3'd0;
         tx_q    <= 8'hFF;
         rx_q    <= 8'hFF;
         rdata_q <= 8'hFF;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b1;
         sce_q   <= 1'b1;
         en_q    <= 1'b0;
         ack_q   <= 1'b0;
         adv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         sce_q   <= sce_d;
         en_q    <= en_d;
         ack_q   <= ack_d;
         adv_q   <= adv_d;
      end
   end

`ifdef SPI_BYTE_ENGINE_OVERRUN_EN
   logic ovr_q, ovr_d;

   always_comb begin
      ovr_d = ovr_q | (frame_end & en_q & adv_q);
   end

   always_ff @(posedge Clk) begin
      if (Reset) ovr_q <= 1'b0;
      else       ovr_q <= ovr_d;
   end

   assign Overrun = ovr_q;
`endif

   assign SCLK          = sclk_q;
   assign MOSI          = mosi_q;
   assign SCE           = sce_q;
   assign host.SendAck  = ack_q;
   assign host.RecvAdv  = adv_q;
   assign host.RecvData = rdata_q;

endmodule
